// File: rtl/tile_pkg.sv
// tile_pkg: shared grid/timing constants and arbiter FSM states for the tile map fetch path
package tile_pkg;
  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_SIZE   = 1200;
  localparam int HVID       = 640;
  localparam int HMAX       = 785;
  localparam int H_PRE      = HMAX - 16;
  typedef enum logic [2:0] {IDLE, VID_RD, VID_WAIT, CPU_RD, CPU_WAIT, CPU_WR, CPU_ACK} state_t;
endpackage

// File: rtl/tile_addr_calc.sv
// tile_addr_calc: maps a tile row/column to its linear map index (row*40+col) with shifts and adds
module tile_addr_calc (
  input  logic [6:0]  row,
  input  logic [5:0]  col,
  output logic [10:0] addr
);
  assign addr = 11'({row, 5'd0}) + 11'({row, 3'd0}) + 11'(col);
endmodule

// File: rtl/tile_fetch_arbiter.sv
// tile_fetch_arbiter: shares the tile map RAM between beam-ahead video fetches and CPU accesses
module tile_fetch_arbiter
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  tile_code,
  output logic        tile_valid,
  output logic        overrun
);
  state_t      state;
  logic        vid_pend;
  logic [10:0] vid_addr;
  logic [10:0] vid_calc;
  logic [7:0]  next_tile;
  logic [10:0] v_inc;
  logic [6:0]  row;
  logic [5:0]  h_tile;
  logic [5:0]  col;
  logic        row_ok;
  logic        col_trig;
  logic        pre_trig;
  logic        trig;
  logic        load;
  logic        cpu_ok;
  assign v_inc    = {1'b0, v_count} + 11'd1;
  assign row      = (h_count >= 10'(HVID)) ? 7'(v_inc >> TILE_SHIFT) : 7'(v_count >> TILE_SHIFT);
  assign row_ok   = row < 7'(GRID_H);
  assign h_tile   = 6'(h_count >> TILE_SHIFT);
  assign col_trig = h_count[3:0] == 4'd1 && h_tile < 6'(GRID_W - 1);
  assign pre_trig = h_count == 10'(H_PRE);
  assign trig     = pix_en && row_ok && (col_trig || pre_trig);
  assign col      = pre_trig ? 6'd0 : h_tile + 6'd1;
  assign load     = pix_en && ((h_count[3:0] == 4'hf && h_count < 10'(HVID - 1)) || h_count == 10'(HMAX - 1));
  assign cpu_ok   = cpu_addr < 11'(MAP_SIZE);
  tile_addr_calc u_addr (
    .row  (row),
    .col  (col),
    .addr (vid_calc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      vid_pend   <= 1'b0;
      vid_addr   <= '0;
      next_tile  <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      tile_code  <= '0;
      tile_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE:
          if (vid_pend) begin
            state    <= VID_RD;
            mem_addr <= vid_addr;
            vid_pend <= 1'b0;
          end else if (cpu_req) begin
            state <= cpu_we ? CPU_WR : CPU_RD;
            if (cpu_ok) begin
              mem_addr  <= cpu_addr;
              mem_we    <= cpu_we;
              mem_wdata <= cpu_wdata;
            end
          end
        VID_RD:   state <= VID_WAIT;
        VID_WAIT: begin
          next_tile <= mem_rdata;
          state     <= IDLE;
        end
        CPU_RD: begin
          state <= cpu_ok ? CPU_WAIT : CPU_ACK;
          if (!cpu_ok) begin
            cpu_rdata <= '0;
            cpu_ack   <= 1'b1;
          end
        end
        CPU_WAIT: begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          state     <= CPU_ACK;
        end
        CPU_WR: begin
          cpu_ack <= 1'b1;
          state   <= CPU_ACK;
        end
        CPU_ACK:  state <= IDLE;
        default:  state <= IDLE;
      endcase
      if (trig) begin
        vid_pend <= 1'b1;
        vid_addr <= vid_calc;
        overrun  <= overrun | vid_pend;
      end
      if (load) begin
        tile_code  <= next_tile;
        tile_valid <= row_ok;
      end else if (h_count >= 10'(HVID))
        tile_valid <= 1'b0;
    end
endmodule

// File: tb/tb_tile_fetch_arbiter.sv
// tb_tile_fetch_arbiter: randomized self-checking bench against a tile-map reference of the screen
module tb_tile_fetch_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  tile_code;
  logic        tile_valid;
  logic        overrun;
  logic [7:0]  ram [0:2047];
  logic [7:0]  ref_map [0:1199];
  int          errors = 0;
  int          checks = 0;
  logic        beam_run = 1'b0;
  logic        chk_on = 1'b0;
  logic [7:0]  rd;
  logic [7:0]  d;
  logic [10:0] a;
  logic [10:0] fa;
  logic        we;
  logic        we_seen;
  int          lat;
  int          n;
  int          acks;
  always #5 clk = ~clk;
  tile_fetch_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .h_count    (h_count),
    .v_count    (v_count),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .tile_code  (tile_code),
    .tile_valid (tile_valid),
    .overrun    (overrun)
  );
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cpu_xfer(input logic w, input logic [10:0] addr, input logic [7:0] wd,
                          output logic [7:0] rdata, output int cycles, output logic saw_we,
                          output logic [10:0] first_addr);
    cpu_req = 1'b1;
    cpu_we = w;
    cpu_addr = addr;
    cpu_wdata = wd;
    cycles = 0;
    saw_we = 1'b0;
    first_addr = '0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) first_addr = mem_addr;
      if (mem_we) saw_we = 1'b1;
    end while (!cpu_ack && cycles < 40);
    check("cpu_ack_seen", cpu_ack, 1);
    rdata = cpu_rdata;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    if (beam_run) begin
      if (pix_en) begin
        if (h_count == 10'd784) begin
          h_count = '0;
          v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
          chk_on = 1'b1;
        end else
          h_count = h_count + 10'd1;
      end
      pix_en = !pix_en;
      if (chk_on) begin
        if (h_count < 640) begin
          check("tile_valid", tile_valid, v_count < 480);
          if (v_count < 480)
            check("tile_code", tile_code, ref_map[int'(v_count >> 4) * 40 + int'(h_count >> 4)]);
        end else if (h_count > 640)
          check("tile_blank", tile_valid, 0);
      end
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end
  initial begin
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) begin
        ram[r * 40 + c] = 8'(r + c);
        ref_map[r * 40 + c] = 8'(r + c);
      end
    v_count = 10'd500;
    h_count = 10'd100;
    repeat (3) @(negedge clk);
    check("rst_ack", cpu_ack, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_tile", tile_code, 0);
    check("rst_valid", tile_valid, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    @(negedge clk);
    cpu_xfer(1'b1, 11'd85, 8'h41, rd, lat, we_seen, fa);
    ref_map[85] = 8'h41;
    check("wr85_lat", lat, 2);
    @(negedge clk);
    cpu_xfer(1'b0, 11'd85, 8'h00, rd, lat, we_seen, fa);
    check("rd85_lat", lat, 3);
    check("rd85_data", rd, 8'h41);
    @(negedge clk);
    cpu_xfer(1'b1, 11'd1200, 8'h5a, rd, lat, we_seen, fa);
    check("oob_wr_lat", lat, 2);
    check("oob_we", we_seen, 0);
    @(negedge clk);
    cpu_xfer(1'b0, 11'd1200, 8'h00, rd, lat, we_seen, fa);
    check("oob_rdata", rd, 0);
    @(negedge clk);
    h_count = 10'd17;
    v_count = 10'd37;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    d = 8'($urandom);
    cpu_xfer(1'b1, 11'd900, d, rd, lat, we_seen, fa);
    ref_map[900] = d;
    check("cont_vid_addr", fa, 82);
    check("cont_lat", lat, 5);
    @(negedge clk);
    h_count = 10'd31;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    check("cont_tile", tile_code, ref_map[82]);
    check("cont_valid", tile_valid, 1);
    check("cont_overrun", overrun, 0);
    @(negedge clk);
    h_count = 10'd760;
    v_count = 10'd36;
    chk_on = 1'b0;
    beam_run = 1'b1;
    n = 0;
    while (!(v_count == 10'd38 && h_count >= 10'd40) && n < 3000) begin
      we = 1'($urandom_range(0, 1));
      a = 11'($urandom_range(400, 1250));
      d = 8'($urandom);
      cpu_xfer(we, a, d, rd, lat, we_seen, fa);
      if (we) begin
        if (a < 11'd1200) ref_map[a] = d;
      end else if (a < 11'd1200)
        check("scan_rd", rd, ref_map[a]);
      else
        check("scan_rd_oob", rd, 0);
      n++;
    end
    beam_run = 1'b0;
    pix_en = 1'b0;
    check("scan_overrun", overrun, 0);
    v_count = 10'd500;
    for (int i = 0; i < 12; i++) begin
      a = 11'($urandom_range(400, 1199));
      @(negedge clk);
      cpu_xfer(1'b0, a, 8'h00, rd, lat, we_seen, fa);
      check("readback", rd, ref_map[a]);
    end
    @(negedge clk);
    h_count = 10'd760;
    v_count = 10'd478;
    chk_on = 1'b0;
    beam_run = 1'b1;
    n = 0;
    while (!(v_count == 10'd481 && h_count >= 10'd50) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check("vblank_reached", v_count, 481);
    beam_run = 1'b0;
    pix_en = 1'b0;
    check("vblank_valid", tile_valid, 0);
    @(negedge clk);
    cpu_xfer(1'b0, 11'd85, 8'h00, rd, lat, we_seen, fa);
    check("rd85_again", rd, 8'h41);
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 11'd85;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ack", cpu_ack, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_rdata", cpu_rdata, 0);
    check("mid_rst_tile", tile_code, 0);
    check("mid_rst_misc", {mem_we, mem_wdata, tile_valid, overrun}, 0);
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      acks += int'(cpu_ack);
    end
    check("post_rst_acks", acks, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
